// File: rtl/bg_pkg.sv
// Shared types for the background tile fetcher: FSM states, tile-map word
// field positions and the next-tile buffer record.
package bg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_LATCH,
    ST_CREQ,
    ST_FULL
  } bg_state_e;

  localparam int unsigned PAL_MSB   = 15;
  localparam int unsigned PAL_LSB   = 12;
  localparam int unsigned HFLIP_BIT = 11;
  localparam int unsigned CODE_MSB  = 10;
  localparam int unsigned CODE_LSB  = 0;

  typedef struct packed {
    logic [3:0]  pal;
    logic        hflip;
    logic [31:0] pix;
  } tile_buf_t;

  function automatic logic [31:0] nibble_rev(input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) r[4*i +: 4] = d[4*(7-i) +: 4];
    return r;
  endfunction

endpackage

// File: rtl/bg_pix_shift.sv
// Pixel shifter with one-deep next-tile buffer: emits one pixel per PCE,
// reloads from the buffer every 8 pixels and flags underrun when it is empty.
module bg_pix_shift
  import bg_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      pce_i,
  input  logic      clear_i,
  input  logic [2:0] fine_x_i,
  input  logic      wr_i,
  input  tile_buf_t wr_tile_i,
  output logic      buf_full_o,
  output logic [7:0] pixel_o,
  output logic      underrun_o
);

  tile_buf_t   buf_q, buf_d;
  logic        buf_v_q, buf_v_d;
  logic [31:0] sh_q, sh_d;
  logic [3:0]  pal_q, pal_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        primed_q, primed_d;
  logic [7:0]  pix_q, pix_d;
  logic        und_q, und_d;
  logic        consume;
  logic        unused_flip;

  assign unused_flip = buf_q.hflip;

  always_comb begin
    buf_d    = buf_q;
    buf_v_d  = buf_v_q;
    sh_d     = sh_q;
    pal_d    = pal_q;
    cnt_d    = cnt_q;
    primed_d = primed_q;
    pix_d    = pix_q;
    und_d    = und_q;
    consume  = 1'b0;
    if (clear_i) begin
      buf_v_d  = 1'b0;
      sh_d     = '0;
      pal_d    = '0;
      cnt_d    = '0;
      primed_d = 1'b0;
      und_d    = 1'b0;
    end else begin
      if (!primed_q) begin
        if (pce_i) pix_d = '0;
        // First tile of the line: drop the fine-scroll pixels up front.
        if (buf_v_q) begin
          consume  = 1'b1;
          sh_d     = buf_q.pix << {fine_x_i, 2'b00};
          pal_d    = buf_q.pal;
          cnt_d    = fine_x_i;
          primed_d = 1'b1;
        end
      end else if (pce_i) begin
        pix_d = {pal_q, sh_q[31:28]};
        sh_d  = sh_q << 4;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          if (buf_v_q) begin
            consume = 1'b1;
            sh_d    = buf_q.pix;
            pal_d   = buf_q.pal;
          end else begin
            sh_d  = '0;
            pal_d = '0;
            und_d = 1'b1;
          end
        end
      end
      // A write landing with a consume keeps the fresh tile valid.
      if (consume) buf_v_d = 1'b0;
      if (wr_i) begin
        buf_d   = wr_tile_i;
        buf_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q    <= '0;
      buf_v_q  <= 1'b0;
      sh_q     <= '0;
      pal_q    <= '0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
      pix_q    <= '0;
      und_q    <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      buf_v_q  <= buf_v_d;
      sh_q     <= sh_d;
      pal_q    <= pal_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
      pix_q    <= pix_d;
      und_q    <= und_d;
    end
  end

  assign buf_full_o = buf_v_q;
  assign pixel_o    = pix_q;
  assign underrun_o = und_q;

endmodule

// File: rtl/bg_tile_fetch.sv
// Background tile fetcher: tile-map read, character ROM row handshake and
// pixel shifter. Optional horizontal flip when BG_HFLIP_EN is defined.
module bg_tile_fetch
  import bg_pkg::*;
#(
  parameter int unsigned CHR_AW = 14
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              PCE,
  input  logic              LINE_START,
  input  logic [7:0]        VPOS,
  input  logic [7:0]        SCRX,
  input  logic [7:0]        SCRY,
  output logic [9:0]        VADR,
  input  logic [15:0]       VDAT,
  output logic              CHR_REQ,
  output logic [CHR_AW-1:0] CHR_ADR,
  input  logic              CHR_ACK,
  input  logic [31:0]       CHR_DAT,
  output logic [7:0]        PIXEL,
  output logic              UNDERRUN
);

  bg_state_e         state_q, state_d;
  logic [7:0]        y_q, y_d;
  logic [4:0]        col_q, col_d;
  logic [2:0]        fx_q, fx_d;
  logic [9:0]        vadr_q, vadr_d;
  logic [CHR_AW-1:0] adr_q, adr_d;
  logic [3:0]        pal_q, pal_d;
  logic              discard_q, discard_d;
  logic              wr, clear, buf_full;
  tile_buf_t         wr_tile;

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    col_d     = col_q;
    fx_d      = fx_q;
    vadr_d    = vadr_q;
    adr_d     = adr_q;
    pal_d     = pal_q;
    discard_d = discard_q;
    wr        = 1'b0;
    clear     = 1'b0;
    if (LINE_START) begin
      y_d   = VPOS + SCRY;
      col_d = SCRX[7:3];
      fx_d  = SCRX[2:0];
      clear = 1'b1;
    end
    unique case (state_q)
      ST_IDLE:  ;
      ST_ISSUE: begin
        vadr_d  = {y_q[7:3], col_q};
        state_d = ST_WAIT;
      end
      ST_WAIT:  state_d = ST_LATCH;
      ST_LATCH: begin
        pal_d   = VDAT[PAL_MSB:PAL_LSB];
        adr_d   = CHR_AW'({VDAT[CODE_MSB:CODE_LSB], y_q[2:0]});
        state_d = ST_CREQ;
      end
      // A new line arriving mid-handshake finishes the old request, then drops its data.
      ST_CREQ: begin
        if (CHR_ACK) begin
          discard_d = 1'b0;
          if (!discard_q && !LINE_START) begin
            wr      = 1'b1;
            col_d   = col_q + 5'd1;
            state_d = ST_FULL;
          end else begin
            state_d = ST_ISSUE;
          end
        end else if (LINE_START) begin
          discard_d = 1'b1;
        end
      end
      ST_FULL:  if (!buf_full) state_d = ST_ISSUE;
      default:  state_d = ST_IDLE;
    endcase
    if (LINE_START && state_q != ST_CREQ) state_d = ST_ISSUE;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      y_q       <= '0;
      col_q     <= '0;
      fx_q      <= '0;
      vadr_q    <= '0;
      adr_q     <= '0;
      pal_q     <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      col_q     <= col_d;
      fx_q      <= fx_d;
      vadr_q    <= vadr_d;
      adr_q     <= adr_d;
      pal_q     <= pal_d;
      discard_q <= discard_d;
    end
  end

`ifdef BG_HFLIP_EN
  logic flip_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) flip_q <= 1'b0;
    else if (state_q == ST_LATCH) flip_q <= VDAT[HFLIP_BIT];
  end

  assign wr_tile = {pal_q, flip_q, (flip_q ? nibble_rev(CHR_DAT) : CHR_DAT)};
`else
  logic unused_hflip;

  assign unused_hflip = VDAT[HFLIP_BIT];
  assign wr_tile      = {pal_q, 1'b0, CHR_DAT};
`endif

  bg_pix_shift u_shift (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .pce_i      (PCE),
    .clear_i    (clear),
    .fine_x_i   (fx_q),
    .wr_i       (wr),
    .wr_tile_i  (wr_tile),
    .buf_full_o (buf_full),
    .pixel_o    (PIXEL),
    .underrun_o (UNDERRUN)
  );

  assign VADR    = vadr_q;
  assign CHR_REQ = (state_q == ST_CREQ);
  assign CHR_ADR = adr_q;

endmodule

// File: tb/tb_bg_tile_fetch.sv
// Directed bench for bg_tile_fetch with a simple character ROM responder.
// Honours BG_HFLIP_EN for the flip expectations.
`timescale 1ns/1ps
module tb_bg_tile_fetch;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        PCE = 1'b0;
  logic        LINE_START = 1'b0;
  logic [7:0]  VPOS = '0;
  logic [7:0]  SCRX = '0;
  logic [7:0]  SCRY = '0;
  logic [9:0]  VADR;
  logic [15:0] VDAT = '0;
  logic        CHR_REQ;
  logic [13:0] CHR_ADR;
  logic        CHR_ACK;
  logic [31:0] CHR_DAT;
  logic [7:0]  PIXEL;
  logic        UNDERRUN;

  logic        ack_r = 1'b0;
  logic        ack_force = 1'b0;
  logic        ack_hold = 1'b0;
  int unsigned ack_delay = 1;
  int unsigned req_cnt = 0;
  logic [31:0] rom_dat = '0;
  int          checks = 0;
  int          failures = 0;

  assign CHR_ACK = ack_r | ack_force;
  assign CHR_DAT = rom_dat;

  always #5 CLK = ~CLK;

  bg_tile_fetch #(.CHR_AW(14)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .PCE        (PCE),
    .LINE_START (LINE_START),
    .VPOS       (VPOS),
    .SCRX       (SCRX),
    .SCRY       (SCRY),
    .VADR       (VADR),
    .VDAT       (VDAT),
    .CHR_REQ    (CHR_REQ),
    .CHR_ADR    (CHR_ADR),
    .CHR_ACK    (CHR_ACK),
    .CHR_DAT    (CHR_DAT),
    .PIXEL      (PIXEL),
    .UNDERRUN   (UNDERRUN)
  );

  // ROM responder: acknowledges ack_delay clocks after REQ rises.
  initial forever begin
    @(posedge CLK);
    #1;
    if (CHR_REQ) begin
      ack_r = (!ack_hold && req_cnt >= ack_delay);
      req_cnt++;
    end else begin
      ack_r   = 1'b0;
      req_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic line_start();
    LINE_START = 1'b1;
    tick(1);
    LINE_START = 1'b0;
  endtask

  task automatic wait_req(input logic level, input string tag);
    int n;
    n = 0;
    while (CHR_REQ !== level && n < 60) begin
      tick(1);
      n++;
    end
    check(tag, 32'(CHR_REQ), 32'(level));
  endtask

  task automatic wait_rise(input string tag);
    wait_req(1'b0, {tag, "_lo"});
    wait_req(1'b1, {tag, "_hi"});
  endtask

  task automatic pix(input string tag, input logic [7:0] exp);
    PCE = 1'b1;
    tick(1);
    PCE = 1'b0;
    check(tag, 32'(PIXEL), 32'(exp));
  endtask

  initial begin
    logic [7:0] e;

    // Reset values
    tick(3);
    check("rst_vadr", 32'(VADR), 32'h0);
    check("rst_req", 32'(CHR_REQ), 32'h0);
    check("rst_adr", 32'(CHR_ADR), 32'h0);
    check("rst_pixel", 32'(PIXEL), 32'h0);
    check("rst_und", 32'(UNDERRUN), 32'h0);
    RST_N = 1'b1;
    tick(2);

    // Basic line: tile 0x005, palette 3, no scroll
    VDAT = 16'h3005; rom_dat = 32'h12345678; ack_delay = 1;
    line_start();
    pix("t1_unprimed", 8'h00);
    check("t1_unprimed_und", 32'(UNDERRUN), 32'h0);
    wait_req(1'b1, "t1_req");
    check("t1_vadr", 32'(VADR), 32'h000);
    check("t1_adr", 32'(CHR_ADR), 32'h028);
    tick(20);
    check("t1_full_noreq", 32'(CHR_REQ), 32'h0);
    rom_dat = 32'hFFFFFFFF; ack_force = 1'b1;
    tick(3);
    ack_force = 1'b0; rom_dat = 32'h12345678;
    for (int i = 0; i < 16; i++) begin
      e = 8'h31 + 8'(i % 8);
      pix($sformatf("t1_pix%0d", i), e);
    end
    check("t1_und", 32'(UNDERRUN), 32'h0);

    // Fine scroll 3, Y=40
    SCRX = 8'h03; VPOS = 8'd40; SCRY = 8'd0;
    line_start();
    wait_rise("t2_req");
    check("t2_vadr", 32'(VADR), 32'd160);
    check("t2_adr", 32'(CHR_ADR), 32'h028);
    tick(20);
    for (int i = 0; i < 5; i++) begin
      e = 8'h34 + 8'(i);
      pix($sformatf("t2_pix%0d", i), e);
    end
    pix("t2_next_tile", 8'h31);

    // Y wrap (250+31=25), column 31 wrapping to 0, then underrun
    SCRX = 8'hF8; VPOS = 8'd250; SCRY = 8'd31;
    line_start();
    wait_rise("t3_req1");
    check("t3_vadr_col31", 32'(VADR), 32'd127);
    check("t3_adr", 32'(CHR_ADR), 32'h029);
    wait_rise("t3_req2");
    check("t3_vadr_wrap", 32'(VADR), 32'd96);
    tick(20);
    ack_hold = 1'b1;
    for (int i = 0; i < 15; i++) begin
      e = 8'h31 + 8'(i % 8);
      pix($sformatf("t3_pix%0d", i), e);
    end
    check("t3_und_before", 32'(UNDERRUN), 32'h0);
    pix("t3_pix15", 8'h38);
    check("t3_und_set", 32'(UNDERRUN), 32'h1);
    for (int i = 0; i < 8; i++) pix($sformatf("t3_zero%0d", i), 8'h00);
    check("t3_req_held", 32'(CHR_REQ), 32'h1);
    ack_hold = 1'b0;
    tick(20);
    check("t3_und_sticky", 32'(UNDERRUN), 32'h1);
    SCRX = 8'h00; VPOS = 8'd0; SCRY = 8'd0;
    line_start();
    check("t3_und_clear", 32'(UNDERRUN), 32'h0);

    // LINE_START during CHR_REQ: old data discarded, new Y used
    rom_dat = 32'h9ABCDEF0; ack_delay = 3;
    wait_rise("t4_req1");
    VPOS = 8'd19;
    line_start();
    check("t4_req_kept", 32'(CHR_REQ), 32'h1);
    check("t4_adr_kept", 32'(CHR_ADR), 32'h028);
    wait_req(1'b0, "t4_req_drop");
    rom_dat = 32'h12345678; ack_delay = 1;
    wait_req(1'b1, "t4_req2");
    check("t4_vadr", 32'(VADR), 32'd64);
    check("t4_adr", 32'(CHR_ADR), 32'h02B);
    tick(20);
    for (int i = 0; i < 8; i++) begin
      e = 8'h31 + 8'(i);
      pix($sformatf("t4_pix%0d", i), e);
    end

    // hflip bit set in the tile word
    VDAT = 16'h1805; VPOS = 8'd0;
    line_start();
    wait_rise("t5_req");
    check("t5_adr", 32'(CHR_ADR), 32'h028);
    tick(20);
    for (int i = 0; i < 8; i++) begin
`ifdef BG_HFLIP_EN
      e = 8'h18 - 8'(i);
`else
      e = 8'h11 + 8'(i);
`endif
      pix($sformatf("t5_pix%0d", i), e);
    end

    // Reset in the middle of a handshake
    ack_delay = 5; VPOS = 8'd8;
    line_start();
    wait_rise("t6_req");
    check("t6_vadr_pre", 32'(VADR), 32'd32);
    RST_N = 1'b0;
    #1;
    check("t6_req_drop", 32'(CHR_REQ), 32'h0);
    check("t6_vadr", 32'(VADR), 32'h0);
    check("t6_adr", 32'(CHR_ADR), 32'h0);
    check("t6_pixel", 32'(PIXEL), 32'h0);
    tick(2);
    RST_N = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bg_tile_fetch.md
BG_TILE_FETCH -- requirements
Module: bg_tile_fetch

Interface
REQ-001 Parameter CHR_AW, default 14: width of the character ROM row address.
REQ-002 CLK  in  1: single clock; all state changes on the rising edge.
REQ-003 RST_N  in  1: reset, asynchronous and active-low.
REQ-004 PCE  in  1: pixel clock enable, one pulse per output pixel.
REQ-005 LINE_START  in  1: one-cycle pulse at start of each scanline's fetch window.
REQ-006 VPOS  in  8: current scanline.
REQ-007 SCRX, SCRY  in  8 each: scroll offsets, sampled on LINE_START.
REQ-008 VADR  out  10: tile-map word address to the 16-bit VRAM read port.
REQ-009 VDAT  in  16: tile-map word; {pal[15:12], hflip[11], code[10:0]}.
REQ-010 CHR_REQ  out  1: character ROM row request.
REQ-011 CHR_ADR  out  CHR_AW: {code, fine_y[2:0]}.
REQ-012 CHR_ACK  in  1: request accepted; CHR_DAT valid in the same cycle.
REQ-013 CHR_DAT  in  32: eight 4-bit pixels, leftmost pixel in bits [31:28].
REQ-014 PIXEL  out  8: {pal, colour}; 0 means transparent.
REQ-015 UNDERRUN  out  1: sticky per line; set when a tile boundary finds no buffered tile.

Function
REQ-016 On LINE_START: latch Y=VPOS+SCRY and X=SCRX (mod 256), set column=X[7:3], fine_x=X[2:0], clear UNDERRUN and both tile buffers, enter ISSUE.
REQ-017 States: IDLE, ISSUE, WAIT, LATCH, CREQ, FULL.
REQ-018 ISSUE drives VADR={Y[7:3], column} for one clock, then goes to WAIT.
REQ-019 WAIT lasts one clock; LATCH samples VDAT (two clocks after VADR changes), then goes to CREQ.
REQ-020 CREQ holds CHR_REQ=1 and CHR_ADR stable until CHR_ACK=1; on CHR_ACK, write {pal, hflip, CHR_DAT} to the next-tile buffer, column+1 (5-bit wrap 31->0), then go to FULL.
REQ-021 FULL waits until the next-tile buffer is consumed, then goes to ISSUE.
REQ-022 At each PCE, PIXEL={pal, shift[31:28]} and the shifter moves 4 bits left.
REQ-023 When the shifter's 8th pixel is emitted, the next-tile buffer loads into the shifter the same cycle; if the buffer is empty, load zero and set UNDERRUN.
REQ-024 First tile: after LINE_START, the first two fetched tiles prime the shifter and the buffer; PCE before priming outputs 0 without setting UNDERRUN.
REQ-025 Initial fine_x pixels of the first tile are discarded internally, without PCE, before first output.
REQ-026 A LINE_START during CREQ keeps CHR_REQ asserted until CHR_ACK, discards that CHR_DAT, then restarts at ISSUE with the new line's values.
REQ-027 A LINE_START in any other state restarts immediately with no bus activity lost.
REQ-028 CHR_ACK while CHR_REQ=0 is ignored.
REQ-029 Buffer load and buffer consume in the same cycle: the consume uses the old contents, and the new data remains valid.

Reset
REQ-030 RST_N low: state IDLE, VADR=0, CHR_REQ=0, CHR_ADR=0, PIXEL=0, UNDERRUN=0, buffers invalid, shifter 0.
REQ-031 Reset mid-handshake drops CHR_REQ immediately; the ROM arbiter tolerates the drop.

Configuration
REQ-032 Macro BG_HFLIP_EN defined: hflip=1 reverses the nibble order of CHR_DAT before buffering.
REQ-033 Macro BG_HFLIP_EN undefined: VDAT[11] is ignored and no flip logic is generated.

Structure
REQ-034 Shared package bg_pkg holds the state enum, the VDAT field positions, and the tile-buffer record type.
REQ-035 One sub-module bg_pix_shift contains the 32-bit shifter, the 8-pixel counter and the load/underrun logic.

Verification
REQ-036 SCRX=0, SCRY=0, VPOS=0, VDAT=16'h3005, CHR_DAT=32'h12345678 with ACK one clock after REQ -> VADR=0, CHR_ADR={11'd5,3'd0}, PIXEL sequence 31,32,...,38.
REQ-037 SCRX=8'h03 -> first VADR column=0; first emitted PIXEL is the 4th nibble (colour 4).
REQ-038 Hold CHR_ACK low for 20 clocks while PCE runs -> UNDERRUN=1 and PIXEL=0 for the affected tile; UNDERRUN clears at the next LINE_START.
REQ-039 LINE_START while CHR_REQ is high, ACK 3 clocks later -> that CHR_DAT is discarded and the next VADR uses the new Y.
REQ-040 With BG_HFLIP_EN, VDAT=16'h1805, CHR_DAT=32'h12345678 -> PIXEL 18,17,...,11; without BG_HFLIP_EN -> 11..18; column 31 wraps to VADR column 0.
